// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// Digit-serial packed-BCD adder controller. A start pulse accepted in IDLE
// latches both operands. One decimal digit per clock then goes through a
// shared single-digit BCD adder, least-significant digit first. The sum is
// accumulated in s, and done pulses for one cycle when s/c/err are final.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  begin an addition (only looked at in IDLE)
//   a, b   DIGITS-wide packed BCD operands, digit 0 in [3:0]
//   busy   high while the digit sequence runs (DIGITS cycles)
//   done   one-cycle pulse once s, c, err are valid
//   s      packed BCD sum register (partial while busy)
//   c      decimal carry out of the top digit
//   err    sticky: some operand nibble was > 9 in this operation

// Single-digit BCD add with carry-in. Non-BCD nibbles still follow the
// same +6 rule, so results stay deterministic even on bad input.
module bcd_digit_add (
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       cin,
  output logic [3:0] sum_d,
  output logic       cout,
  output logic       bad
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cin};
    // Up to 31+6 may wrap the 5-bit value; only the low nibble is kept.
    adj = raw + 5'd6;
    if (raw > 5'd9) begin
      sum_d = adj[3:0];
      cout  = 1'b1;
    end else begin
      sum_d = raw[3:0];
      cout  = 1'b0;
    end
    bad = (a_d > 4'd9) | (b_d > 4'd9);
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] s,
  output logic                c,
  output logic                err
);
  localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic                    cy;
  logic [DIGITS-1:0][3:0]  op_a;
  logic [DIGITS-1:0][3:0]  op_b;
  logic [DIGITS-1:0][3:0]  s_q;

  logic [3:0] d_sum;
  logic       d_cout;
  logic       d_bad;

  // The shared digit stage always looks at the current digit of the
  // latched operands, never at the live a/b inputs.
  bcd_digit_add u_dig (
    .a_d   (op_a[idx]),
    .b_d   (op_b[idx]),
    .cin   (cy),
    .sum_d (d_sum),
    .cout  (d_cout),
    .bad   (d_bad)
  );

  assign s = s_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cy    <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      s_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            s_q   <= '0;
            c     <= 1'b0;
            err   <= 1'b0;
            cy    <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_q[idx] <= d_sum;
          cy       <= d_cout;
          if (d_bad) err <= 1'b1;
          if (idx == LAST) begin
            c     <= d_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
module tb_bcd_serial_add_ctrl;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [4*D-1:0] a, b;
  logic          busy, done, c, err;
  logic [4*D-1:0] s;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        c;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .c(c), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal integer addition when operands are proper BCD,
  // otherwise the per-digit +6 rule applied in a plain loop.
  task automatic ref_add(input logic [15:0] ra, input logic [15:0] rb,
                         output logic [15:0] rs, output logic rc, output logic rerr);
    int va, vb, tot, t, cyv;
    logic [15:0] tmpa, tmpb;
    rerr = 1'b0;
    tmpa = ra; tmpb = rb;
    for (int i = 0; i < D; i++)
      if (tmpa[4*i +: 4] > 9 || tmpb[4*i +: 4] > 9) rerr = 1'b1;
    rs = '0;
    if (!rerr) begin
      va = 0; vb = 0;
      for (int i = D - 1; i >= 0; i--) begin
        va = va * 10 + int'(tmpa[4*i +: 4]);
        vb = vb * 10 + int'(tmpb[4*i +: 4]);
      end
      tot = va + vb;
      rc  = (tot >= 10000);
      tot = tot % 10000;
      for (int i = 0; i < D; i++) begin
        rs[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end else begin
      cyv = 0;
      for (int i = 0; i < D; i++) begin
        t = int'(tmpa[4*i +: 4]) + int'(tmpb[4*i +: 4]) + cyv;
        if (t > 9) begin
          rs[4*i +: 4] = 4'((t + 6) % 16);
          cyv = 1;
        end else begin
          rs[4*i +: 4] = 4'(t);
          cyv = 0;
        end
      end
      rc = (cyv != 0);
    end
  endtask

  // One full operation; mess=1 scrambles a/b and pulses start while busy.
  task automatic do_op(input string name, input logic [15:0] oa, input logic [15:0] ob,
                       input logic [15:0] es, input logic ec, input logic eerr, input bit mess);
    int n, bcnt;
    @(negedge clk);
    a = oa; b = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy@E0"}, {31'b0, busy}, 32'd1);
    n = 0; bcnt = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      n++;
      if (mess) begin
        a = 16'($urandom); b = 16'($urandom);
        start = (n == 1);
      end
    end
    start = 1'b0;
    chk({name, " latency"}, n, D);
    chk({name, " busy cycles"}, bcnt, D);
    chk({name, " s"}, {16'b0, s}, {16'b0, es});
    chk({name, " c"}, {31'b0, c}, {31'b0, ec});
    chk({name, " err"}, {31'b0, err}, {31'b0, eerr});
    chk({name, " busy@done"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({name, " done pulse width"}, {31'b0, done}, 32'd0);
    chk({name, " s held"}, {16'b0, s}, {16'b0, es});
  endtask

  initial begin
    logic [15:0] ra, rb, rs;
    logic        rc, re;
    int          last, gap, seen, k;

    tbl[0] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h5678, 16'h8765, 16'h4443, 1'b1, 1'b0};
    tbl[3] = '{16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1};
    tbl[4] = '{16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[6] = '{16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0F00, 16'h0100, 16'h1600, 1'b0, 1'b1};

    // Reset held with start asserted.
    rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h1111;
    @(negedge clk); @(negedge clk);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst s", {16'b0, s}, 32'd0);
    chk("rst c", {31'b0, c}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst idle", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, tbl[i].err, 1'b0);

    // Operands changing and start pulsing during RUN must not matter.
    do_op("mess", 16'h2468, 16'h1357, 16'h3825, 1'b0, 1'b0, 1'b1);

    // Start held continuously: back-to-back results every D+1 cycles.
    @(negedge clk);
    a = 16'h0005; b = 16'h0004; start = 1'b1;
    last = -1; seen = 0; k = 0;
    while (seen < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (done) begin
        chk("hold s", {16'b0, s}, 32'h0009);
        if (last >= 0) begin
          gap = k - last;
          chk("hold interval", gap, D + 1);
        end
        last = k; seen++;
      end
    end
    chk("hold done count", seen, 3);
    start = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset at the second RUN edge aborts the operation.
    a = 16'h9999; b = 16'h9999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort s", {16'b0, s}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no done", seen, 0);
    do_op("after abort", 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < D; j++) begin
        if (i % 5 == 4) begin
          ra[4*j +: 4] = 4'($urandom_range(0, 15));
          rb[4*j +: 4] = 4'($urandom_range(0, 15));
        end else begin
          ra[4*j +: 4] = 4'($urandom_range(0, 9));
          rb[4*j +: 4] = 4'($urandom_range(0, 9));
        end
      end
      ref_add(ra, rb, rs, rc, re);
      do_op($sformatf("rnd%0d", i), ra, rb, rs, rc, re, (i % 3 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Digit-serial controller for multi-digit packed-BCD addition. It latches two DIGITS-wide packed-BCD operands on a start pulse and steps one decimal digit per clock through a single-digit BCD add stage with carry-in, least-significant digit first. It accumulates the result digits in a register and reports completion with a one-cycle done pulse. It sits between operand sources and result consumers wherever a wide BCD sum is needed and one shared digit adder per operation is acceptable.

## Interface
Parameters:
- DIGITS, default 4: number of BCD digits per operand (≥1).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]; sampled on the accepted start.
- b  input  4*DIGITS  operand B, same format as a.
- busy  output  1  high while the digit sequence runs.
- done  output  1  one-cycle pulse when s, c and err are valid.
- s  output  4*DIGITS  packed-BCD sum register.
- c  output  1  final decimal carry out of digit DIGITS-1.
- err  output  1  sticky flag: a nibble >9 was seen in a or b during the current operation.

## Operation
- States: IDLE and RUN. A digit index idx runs 0..DIGITS-1, and an internal carry register cy holds the digit-to-digit carry.
- Reset (rst_n=0 at a rising edge) sets state=IDLE, idx=0, cy=0, busy=0, done=0, s=0, c=0, err=0. Reset overrides every other event.
- IDLE with start=1:
  - latch a and b into operand registers;
  - clear s, c, err and cy; set idx=0;
  - state→RUN, busy→1.
- IDLE with start=0: hold all registers; done→0.
- RUN, each cycle, with digit i=idx:
  - sum = A_i + B_i + cy (5-bit unsigned).
  - If sum>9: digit = (sum+6) mod 16 and cy_next = 1. Otherwise digit = sum[3:0] and cy_next = 0.
  - Write the digit to s[4i+3:4i] and set cy ← cy_next.
  - If A_i>9 or B_i>9, set err←1. Arithmetic still follows the formula above, so the result stays deterministic.
  - If idx = DIGITS-1: c←cy_next, state→IDLE, busy→0, done→1. Otherwise idx←idx+1.
- start during RUN is ignored. The latched operands are unaffected by later changes to a and b.
- s, c and err hold their values after done until the next accepted start clears them.
- s is partially updated during RUN. It is valid only from the done cycle onward.

## Timing
- Let start be sampled high in IDLE at edge E0. Digit i is written at edge E(i+1).
- At edge E(DIGITS) the last digit is written and done, c and err become final. done is high for exactly the cycle following E(DIGITS).
- busy is high from E0 through E(DIGITS), i.e. DIGITS cycles.
- Latency from start edge to done: DIGITS cycles.
- A start held high during the done cycle is accepted at E(DIGITS+1). The minimum issue interval is therefore DIGITS+1 cycles.
- Reset mid-RUN aborts the operation: done never pulses, and all outputs take their reset values at that edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Bench runs with DIGITS=4.
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, s=16'h0000, c=0, err=0; no operation starts.
- No carry: a=16'h1234, b=16'h4321, start for 1 cycle -> busy high 4 cycles, done pulses once 4 cycles after the start edge, s=16'h5555, c=0, err=0.
- Full carry ripple: a=16'h9999, b=16'h0001 -> s=16'h0000, c=1, err=0. Then a=16'h5678, b=16'h8765 -> s=16'h4443, c=1.
- Invalid digit: a=16'h00A0, b=16'h0000 -> s=16'h0100, c=0, err=1. The next operation a=16'h0001, b=16'h0001 -> err cleared, s=16'h0002.
- Start handling:
  - hold start=1 continuously with a=16'h0005, b=16'h0004 -> results every 5 cycles, s=16'h0009;
  - change a and b during RUN -> no effect on the result;
  - pulse start during RUN -> ignored.
- Reset mid-operation: start a=16'h9999, b=16'h9999, drive rst_n=0 at the second RUN edge -> busy=0 and s=0 at that edge, no done pulse. A fresh start afterwards gives s=16'h9998, c=1.
